// File: rtl/wb_arb_pkg.sv
// Shared constants and state encoding for the Wishbone port arbiter.
package wb_arb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_prio_enc.sv
// Round-robin priority encoder: first set req bit after 'last', wrapping at NR_PORTS.
module rr_prio_enc #(
  parameter int NR_PORTS = 3,
  parameter int IDX_W    = 2
) (
  input  logic [NR_PORTS-1:0] req,
  input  logic [IDX_W-1:0]    last,
  output logic [NR_PORTS-1:0] win_onehot,
  output logic [IDX_W-1:0]    win_idx,
  output logic                win_vld
);

  int unsigned cand;

  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    win_vld    = 1'b0;
    cand       = 0;
    // Walk the distances from farthest to nearest so the nearest requester wins.
    for (int unsigned k = NR_PORTS; k > 0; k--) begin
      cand = (k + 32'(last)) % NR_PORTS;
      if (|(req & (NR_PORTS'(1) << cand))) begin
        win_onehot = NR_PORTS'(1) << cand;
        win_idx    = IDX_W'(cand);
        win_vld    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin, burst-aware Wishbone port arbiter for one wb_clk domain.
// Optional forced-release timeout enabled by defining WB_ARB_TIMEOUT_EN.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NR_PORTS = 3,
  parameter int IDX_W    = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic                  wb_clk,
  input  logic                  wb_rst,
  input  logic [NR_PORTS-1:0]   cyc_i,
  input  logic [NR_PORTS-1:0]   stb_i,
  input  logic [3*NR_PORTS-1:0] cti_i,
  input  logic                  ack_i,
  output logic [NR_PORTS-1:0]   grant_o,
  output logic [IDX_W-1:0]      grant_idx_o,
  output logic                  grant_vld_o,
  output logic                  timeout_o
);

  arb_state_t            state_q, state_d;
  logic [NR_PORTS-1:0]   req;
  logic [NR_PORTS-1:0]   win_onehot;
  logic [IDX_W-1:0]      win_idx;
  logic                  win_vld;
  logic [IDX_W-1:0]      last_q;
  logic [2:0]            cti_g;
  logic                  cyc_g;
  logic                  release_c;
  logic                  tmo_hit;

  assign req = cyc_i & stb_i;

  rr_prio_enc #(
    .NR_PORTS (NR_PORTS),
    .IDX_W    (IDX_W)
  ) u_prio_enc (
    .req        (req),
    .last       (last_q),
    .win_onehot (win_onehot),
    .win_idx    (win_idx),
    .win_vld    (win_vld)
  );

  // The one-hot grant selects the granted port's cyc/cti without a variable index.
  always_comb begin
    cti_g = CTI_CLASSIC;
    for (int unsigned p = 0; p < NR_PORTS; p++) begin
      if (grant_o[p]) cti_g = cti_i[3*p +: 3];
    end
  end

  assign cyc_g     = |(cyc_i & grant_o);
  assign release_c = !cyc_g
                   | (ack_i & ((cti_g == CTI_EOB) | (cti_g == CTI_CLASSIC)))
                   | tmo_hit;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (win_vld) state_d = ST_GRANT;
      ST_GRANT:   if (release_c) state_d = ST_RELEASE;
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q     <= ST_IDLE;
      grant_o     <= '0;
      grant_idx_o <= '0;
      grant_vld_o <= 1'b0;
      last_q      <= IDX_W'(NR_PORTS - 1);
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && win_vld) begin
        grant_o     <= win_onehot;
        grant_idx_o <= win_idx;
        grant_vld_o <= 1'b1;
      end else if (state_q == ST_GRANT && release_c) begin
        grant_o     <= '0;
        grant_vld_o <= 1'b0;
        last_q      <= grant_idx_o;
      end
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] tmo_cnt;

  // Release fires on the ack-less cycle that would bring the count up to TIMEOUT.
  assign tmo_hit = (state_q == ST_GRANT) && !ack_i && (tmo_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      tmo_cnt   <= '0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= tmo_hit;
      if ((state_q == ST_IDLE && win_vld) || ack_i) tmo_cnt <= '0;
      else if (state_q == ST_GRANT)                 tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end
`else
  assign tmo_hit   = 1'b0;
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (NR_PORTS=3, TIMEOUT=8).
module tb_wb_port_arbiter;

  logic       wb_clk = 1'b0;
  logic       wb_rst;
  logic [2:0] cyc_i, stb_i;
  logic [8:0] cti_i;
  logic       ack_i;
  logic [2:0] grant_o;
  logic [1:0] grant_idx_o;
  logic       grant_vld_o;
  logic       timeout_o;

  int n_chk  = 0;
  int n_fail = 0;

  wb_port_arbiter #(
    .NR_PORTS (3),
    .IDX_W    (2),
    .TIMEOUT  (8)
  ) dut (
    .wb_clk      (wb_clk),
    .wb_rst      (wb_rst),
    .cyc_i       (cyc_i),
    .stb_i       (stb_i),
    .cti_i       (cti_i),
    .ack_i       (ack_i),
    .grant_o     (grant_o),
    .grant_idx_o (grant_idx_o),
    .grant_vld_o (grant_vld_o),
    .timeout_o   (timeout_o)
  );

  always #5 wb_clk = ~wb_clk;

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [2:0] ports);
    cyc_i = ports;
    stb_i = ports;
  endtask

  initial begin
    wb_rst = 1'b1;
    req(3'b000);
    cti_i = '0;
    ack_i = 1'b0;
    tick();
    tick();
    chk("rst_grant", 32'(grant_o), 32'h0);
    chk("rst_idx", 32'(grant_idx_o), 32'h0);
    chk("rst_vld", 32'(grant_vld_o), 32'h0);
    chk("rst_tmo", 32'(timeout_o), 32'h0);
    wb_rst = 1'b0;

    // Test 1: port1 classic single, ack after 3 grant cycles
    req(3'b010);
    tick();
    chk("t1_grant", 32'(grant_o), 32'h2);
    chk("t1_idx", 32'(grant_idx_o), 32'h1);
    chk("t1_vld", 32'(grant_vld_o), 32'h1);
    tick();
    tick();
    chk("t1_hold", 32'(grant_o), 32'h2);
    ack_i = 1'b1;
    tick();
    chk("t1_rel_grant", 32'(grant_o), 32'h0);
    chk("t1_rel_vld", 32'(grant_vld_o), 32'h0);
    ack_i = 1'b0;
    req(3'b111);
    tick();
    chk("t1_gap", 32'(grant_o), 32'h0);
    tick();
    chk("t1_next_after_last1", 32'(grant_o), 32'h4);
    chk("t1_next_idx", 32'(grant_idx_o), 32'h2);

    // Asynchronous reset while granted
    wb_rst = 1'b1;
    #2;
    chk("async_rst_grant", 32'(grant_o), 32'h0);
    chk("async_rst_vld", 32'(grant_vld_o), 32'h0);
    wb_rst = 1'b0;

    // Test 2: all ports request, single cycles, ack held high
    ack_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t2_grant%0d", i), 32'(grant_o), 32'h1 << (i % 3));
      chk($sformatf("t2_idx%0d", i), 32'(grant_idx_o), 32'(i % 3));
      tick();
      chk($sformatf("t2_rel%0d", i), 32'(grant_o), 32'h0);
      tick();
      chk($sformatf("t2_idle%0d", i), 32'(grant_o), 32'h0);
    end

    // Test 3: port2 4-beat burst, port0 also requesting (last=0)
    ack_i = 1'b0;
    req(3'b101);
    cti_i = {3'b010, 3'b000, 3'b000};
    tick();
    chk("t3_grant2", 32'(grant_o), 32'h4);
    ack_i = 1'b1;
    for (int b = 0; b < 3; b++) begin
      tick();
      chk($sformatf("t3_beat%0d", b), 32'(grant_o), 32'h4);
    end
    cti_i = {3'b111, 3'b000, 3'b000};
    tick();
    chk("t3_eob_rel", 32'(grant_o), 32'h0);
    ack_i = 1'b0;
    req(3'b001);
    cti_i = '0;
    tick();
    chk("t3_gap", 32'(grant_o), 32'h0);
    tick();
    chk("t3_port0", 32'(grant_o), 32'h1);

    // Test 4: port0 drops cyc mid-burst, port1 pending
    req(3'b011);
    cti_i = {3'b000, 3'b000, 3'b010};
    ack_i = 1'b1;
    tick();
    chk("t4_beat0", 32'(grant_o), 32'h1);
    tick();
    chk("t4_beat1", 32'(grant_o), 32'h1);
    ack_i = 1'b0;
    req(3'b010);
    tick();
    chk("t4_cyc_drop_rel", 32'(grant_o), 32'h0);
    tick();
    chk("t4_gap", 32'(grant_o), 32'h0);
    tick();
    chk("t4_port1", 32'(grant_o), 32'h2);
    chk("t4_idx", 32'(grant_idx_o), 32'h1);

    // Test 5: port1 granted, no ack
    cti_i = {3'b000, 3'b010, 3'b000};
`ifdef WB_ARB_TIMEOUT_EN
    for (int c = 0; c < 7; c++) begin
      tick();
      chk($sformatf("t5_hold%0d", c), 32'(grant_o), 32'h2);
      chk($sformatf("t5_notmo%0d", c), 32'(timeout_o), 32'h0);
    end
    tick();
    chk("t5_tmo_pulse", 32'(timeout_o), 32'h1);
    chk("t5_tmo_rel", 32'(grant_o), 32'h0);
    tick();
    chk("t5_tmo_end", 32'(timeout_o), 32'h0);
    tick();
    chk("t5_sole_regrant", 32'(grant_o), 32'h2);
`else
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("t5_hold%0d", c), 32'(grant_o), 32'h2);
      chk($sformatf("t5_notmo%0d", c), 32'(timeout_o), 32'h0);
    end
    req(3'b000);
    tick();
    chk("t5_rel", 32'(grant_o), 32'h0);
    req(3'b010);
    tick();
    chk("t5_gap", 32'(grant_o), 32'h0);
    tick();
    chk("t5_sole_regrant", 32'(grant_o), 32'h2);
`endif

    // Test 6: reset mid-burst on port1, then ports 1 and 2 request
    ack_i = 1'b1;
    tick();
    chk("t6_beat", 32'(grant_o), 32'h2);
    wb_rst = 1'b1;
    #2;
    chk("t6_async_grant", 32'(grant_o), 32'h0);
    chk("t6_async_vld", 32'(grant_vld_o), 32'h0);
    chk("t6_async_idx", 32'(grant_idx_o), 32'h0);
    chk("t6_async_tmo", 32'(timeout_o), 32'h0);
    tick();
    wb_rst = 1'b0;
    ack_i  = 1'b0;
    cti_i  = '0;
    req(3'b110);
    tick();
    chk("t6_port1_first", 32'(grant_o), 32'h2);
    chk("t6_idx", 32'(grant_idx_o), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
